// File: rtl/line_window_3x3_if.sv
// Pixel-in / window-out stream bundle for line_window_3x3.
// LINE_WINDOW_COORD_EN adds the window-centre coordinate signals.
interface line_window_3x3_if #(
    parameter int PIX_W = 8
`ifdef LINE_WINDOW_COORD_EN
   ,parameter int ROW_W = 6,
    parameter int COL_W = 6
`endif
);
    logic [PIX_W-1:0]   PIX_IN;
    logic               PIX_VALID;
    logic               SOF;
    logic               PIX_READY;
    logic [9*PIX_W-1:0] WIN_OUT;
    logic               WIN_VALID;
    logic               WIN_READY;
    logic               FRAME_DONE;
`ifdef LINE_WINDOW_COORD_EN
    logic [ROW_W-1:0]   WIN_ROW;
    logic [COL_W-1:0]   WIN_COL;
`endif

    modport master (
        output PIX_IN, PIX_VALID, SOF, WIN_READY,
        input  PIX_READY, WIN_OUT, WIN_VALID, FRAME_DONE
`ifdef LINE_WINDOW_COORD_EN
       ,input  WIN_ROW, WIN_COL
`endif
    );

    modport slave (
        input  PIX_IN, PIX_VALID, SOF, WIN_READY,
        output PIX_READY, WIN_OUT, WIN_VALID, FRAME_DONE
`ifdef LINE_WINDOW_COORD_EN
       ,output WIN_ROW, WIN_COL
`endif
    );
endinterface

// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator with two-row line buffers.
// Optional LINE_WINDOW_COORD_EN: registered window-centre WIN_ROW/WIN_COL.
module line_window_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic             CLK,
    input  logic             RESETB,
    line_window_3x3_if.slave s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    typedef enum logic {FILL, STREAM} state_t;

    logic [PIX_W-1:0]   r_lb0 [IMG_W];
    logic [PIX_W-1:0]   r_lb1 [IMG_W];
    logic [9*PIX_W-1:0] r_win;
    logic [9*PIX_W-1:0] r_wout;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    state_t             r_state;
    logic               r_wvalid;
    logic               r_fdone;
`ifdef LINE_WINDOW_COORD_EN
    logic [RW-1:0]      r_wrow;
    logic [CW-1:0]      r_wcol;
`endif

    logic               w_ready;
    logic               w_acc;
    logic [CW-1:0]      w_c;
    logic [RW-1:0]      w_r;
    logic [PIX_W-1:0]   w_top;
    logic [PIX_W-1:0]   w_mid;
    logic               w_last;
    logic               w_emit;
    logic [9*PIX_W-1:0] w_nwin;

    assign w_ready = !r_wvalid || s.WIN_READY;
    assign w_acc   = s.PIX_VALID && w_ready;

    // SOF pins the accepted pixel to (0,0) whatever the counters say
    assign w_c     = s.SOF ? '0 : r_col;
    assign w_r     = s.SOF ? '0 : r_row;
    assign w_top   = r_lb1[w_c];
    assign w_mid   = r_lb0[w_c];
    assign w_last  = (w_r == R_LAST) && (w_c == C_LAST);
    assign w_emit  = w_acc && (r_state == STREAM)
                   && (w_c >= CW'(2));

    always_comb begin
        w_nwin = '0;
        for (int i = 0; i < 3; i++) begin
            w_nwin[PIX_W*(3*i)   +: PIX_W] = r_win[PIX_W*(3*i+1) +: PIX_W];
            w_nwin[PIX_W*(3*i+1) +: PIX_W] = r_win[PIX_W*(3*i+2) +: PIX_W];
        end
        w_nwin[PIX_W*2 +: PIX_W] = w_top;
        w_nwin[PIX_W*5 +: PIX_W] = w_mid;
        w_nwin[PIX_W*8 +: PIX_W] = s.PIX_IN;
    end

    // Line buffers hold no reset; FILL overwrites them before any use
    always_ff @(posedge CLK) begin
        if (w_acc) begin
            r_lb1[w_c] <= w_mid;
            r_lb0[w_c] <= s.PIX_IN;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_win   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_state <= FILL;
        end else if (w_acc) begin
            r_win <= w_nwin;
            if (w_c == C_LAST) begin
                r_col <= '0;
                r_row <= (w_r == R_LAST) ? '0 : w_r + RW'(1);
            end else begin
                r_col <= w_c + CW'(1);
                r_row <= w_r;
            end
            unique case (r_state)
                FILL: begin
                    if (w_r == RW'(1) && w_c == C_LAST)
                        r_state <= STREAM;
                end
                STREAM: begin
                    if (s.SOF || w_last)
                        r_state <= FILL;
                end
                default: r_state <= FILL;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_wvalid <= 1'b0;
            r_fdone  <= 1'b0;
            r_wout   <= '0;
`ifdef LINE_WINDOW_COORD_EN
            r_wrow   <= '0;
            r_wcol   <= '0;
`endif
        end else if (w_emit) begin
            r_wvalid <= 1'b1;
            r_fdone  <= w_last;
            r_wout   <= w_nwin;
`ifdef LINE_WINDOW_COORD_EN
            r_wrow   <= w_r - RW'(1);
            r_wcol   <= w_c - CW'(1);
`endif
        end else if (s.WIN_READY) begin
            r_wvalid <= 1'b0;
            r_fdone  <= 1'b0;
        end
    end

    assign s.PIX_READY  = w_ready;
    assign s.WIN_OUT    = r_wout;
    assign s.WIN_VALID  = r_wvalid;
    assign s.FRAME_DONE = r_fdone;
`ifdef LINE_WINDOW_COORD_EN
    assign s.WIN_ROW    = r_wrow;
    assign s.WIN_COL    = r_wcol;
`endif
endmodule

// File: tb/tb_line_window_3x3.sv
// Directed scoreboard bench for line_window_3x3 on a 4x4 image.
// Build with LINE_WINDOW_COORD_EN to also check WIN_ROW/WIN_COL.
module tb_line_window_3x3;
    localparam int W = 4;
    localparam int H = 4;
    localparam int P = 8;

    typedef struct {
        logic [9*P-1:0] win;
        logic           done;
        logic [1:0]     r;
        logic [1:0]     c;
    } exp_t;

    logic CLK = 1'b0;
    logic RESETB = 1'b0;

    line_window_3x3_if #(
        .PIX_W(P)
`ifdef LINE_WINDOW_COORD_EN
       ,.ROW_W(2), .COL_W(2)
`endif
    ) bus ();

    line_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .CLK(CLK), .RESETB(RESETB), .s(bus)
    );

    always #5 CLK = ~CLK;

    exp_t           q[$];
    int             n_vec = 0;
    int             n_err = 0;
    int             n_win = 0;
    int             gaps = 0;
    logic [9*P-1:0] first_win;
    logic [P-1:0]   img [H][W];
    int             m_r = 0;
    int             m_c = 0;

    task automatic chk(input string tag, input logic [9*P-1:0] obs,
                       input logic [9*P-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9*P-1:0] ramp_win(input int b);
        logic [9*P-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[P*(3*i+j) +: P] = P'(b + W*i + j);
        return w;
    endfunction

    // Frame-image reference: window = pixels (r-2..r, c-2..c)
    task automatic model(input logic [P-1:0] pix, input logic sof);
        exp_t e;
        if (sof) begin
            m_r = 0;
            m_c = 0;
        end
        img[m_r][m_c] = pix;
        if (m_r >= 2 && m_c >= 2) begin
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[P*(3*i+j) +: P] = img[m_r-2+i][m_c-2+j];
            e.done = (m_r == H-1 && m_c == W-1);
            e.r = 2'(m_r - 1);
            e.c = 2'(m_c - 1);
            q.push_back(e);
        end
        if (m_c == W-1) begin
            m_c = 0;
            m_r = (m_r == H-1) ? 0 : m_r + 1;
        end else begin
            m_c++;
        end
    endtask

    task automatic send(input logic [P-1:0] pix, input logic sof);
        int t;
        t = 0;
        @(negedge CLK);
        bus.PIX_IN = pix;
        bus.SOF = sof;
        bus.PIX_VALID = 1'b1;
        #1;
        while (!bus.PIX_READY && t < 100) begin
            gaps++;
            @(negedge CLK);
            #1;
            t++;
        end
        if (t >= 100) chk("pix_ready_timeout", 72'(bus.PIX_READY), 72'(1));
        model(pix, sof);
        @(posedge CLK);
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        bus.PIX_VALID = 1'b0;
        bus.SOF = 1'b0;
        repeat (n) @(negedge CLK);
        #2;
    endtask

    task automatic drain_check(input string tag, input int nexp);
        chk({tag, "_queue_left"}, 72'(q.size()), 72'(0));
        chk({tag, "_windows"}, 72'(n_win), 72'(nexp));
        chk({tag, "_valid_idle"}, 72'(bus.WIN_VALID), 72'(0));
        chk({tag, "_done_idle"}, 72'(bus.FRAME_DONE), 72'(0));
    endtask

    always @(negedge CLK) begin
        exp_t e;
        #1;
        if (RESETB && bus.WIN_VALID && bus.WIN_READY) begin
            if (q.size() == 0) begin
                chk("unexpected_window", 72'(q.size()), 72'(1));
            end else begin
                e = q.pop_front();
                if (n_win == 0) first_win = bus.WIN_OUT;
                chk("win_out", bus.WIN_OUT, e.win);
                chk("frame_done", 72'(bus.FRAME_DONE), 72'(e.done));
`ifdef LINE_WINDOW_COORD_EN
                chk("win_row", 72'(bus.WIN_ROW), 72'(e.r));
                chk("win_col", 72'(bus.WIN_COL), 72'(e.c));
`endif
            end
            n_win++;
        end
    end

    initial begin
        bus.PIX_IN = '0;
        bus.PIX_VALID = 1'b0;
        bus.SOF = 1'b0;
        bus.WIN_READY = 1'b1;

        // reset state
        #12;
        chk("rst_win_valid", 72'(bus.WIN_VALID), 72'(0));
        chk("rst_frame_done", 72'(bus.FRAME_DONE), 72'(0));
        chk("rst_win_out", bus.WIN_OUT, 72'(0));
        chk("rst_pix_ready", 72'(bus.PIX_READY), 72'(1));
        @(negedge CLK);
        RESETB = 1'b1;

        // plain ramp, checks one-cycle latency around pixel 10
        n_win = 0;
        for (int i = 0; i < 16; i++) begin
            send(P'(i), i == 0);
            if (i == 9 || i == 10) begin
                #1;
                chk("latency_valid", 72'(bus.WIN_VALID), 72'(i == 10));
            end
        end
        idle(3);
        drain_check("ramp", 4);
        chk("ramp_first", first_win, ramp_win(0));

        // backpressure for 3 cycles after first window
        n_win = 0;
        for (int i = 0; i < 11; i++) send(P'(i), i == 0);
        @(negedge CLK);
        bus.WIN_READY = 1'b0;
        bus.PIX_IN = P'(11);
        bus.SOF = 1'b0;
        bus.PIX_VALID = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_pix_ready", 72'(bus.PIX_READY), 72'(0));
            chk("bp_win_valid", 72'(bus.WIN_VALID), 72'(1));
            chk("bp_win_hold", bus.WIN_OUT, ramp_win(0));
            @(negedge CLK);
        end
        bus.WIN_READY = 1'b1;
        bus.PIX_VALID = 1'b0;
        for (int i = 11; i < 16; i++) send(P'(i), 1'b0);
        idle(3);
        drain_check("bp", 4);

        // SOF mid-frame resynchronises
        n_win = 0;
        for (int i = 0; i < 6; i++) send(P'(i), i == 0);
        for (int i = 0; i < 16; i++) send(P'(100 + i), i == 0);
        idle(3);
        drain_check("sof", 4);
        chk("sof_first", first_win, ramp_win(100));

        // async reset mid-frame, then ramp without SOF
        for (int i = 0; i < 10; i++) send(P'(i), i == 0);
        @(negedge CLK);
        bus.PIX_VALID = 1'b0;
        RESETB = 1'b0;
        #1;
        chk("mid_rst_valid", 72'(bus.WIN_VALID), 72'(0));
        chk("mid_rst_ready", 72'(bus.PIX_READY), 72'(1));
        @(negedge CLK);
        RESETB = 1'b1;
        m_r = 0;
        m_c = 0;
        n_win = 0;
        for (int i = 0; i < 16; i++) send(P'(i), 1'b0);
        idle(3);
        drain_check("rst", 4);
        chk("rst_first", first_win, ramp_win(0));

        // two back-to-back frames, no bubbles
        n_win = 0;
        gaps = 0;
        for (int i = 0; i < 32; i++) send(P'(i * 3 + 7), i == 0);
        idle(3);
        drain_check("b2b", 8);
        chk("b2b_gaps", 72'(gaps), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
